// File: rtl/rnic_lite_req_arbiter.sv
// rtl/rnic_lite_req_arbiter.sv - round-robin arbiter sharing one AXI-Lite master port among NUM_REQ requesters
// Optional watchdog abort: define RNIC_LITE_ARB_TIMEOUT_EN.

module rnic_lite_req_arbiter #(
   parameter int C_S_AXI_LITE_ADDR_WIDTH = 32,
   parameter int C_S_AXI_LITE_DATA_WIDTH = 32,
   parameter int NUM_REQ                 = 3,
   parameter int TIMEOUT_CYCLES          = 1024
) (
   input  logic                                   s_axi_lite_aclk,
   input  logic                                   s_axi_lite_arstn,
   input  logic [NUM_REQ-1:0]                     req_valid,
   input  logic [NUM_REQ-1:0]                     req_wr,
   input  logic [NUM_REQ*C_S_AXI_LITE_ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_REQ*C_S_AXI_LITE_DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]                     req_ack,
   output logic [NUM_REQ-1:0]                     req_done,
   output logic [C_S_AXI_LITE_DATA_WIDTH-1:0]     rsp_data,
   output logic [1:0]                             rsp_resp,
   output logic                                   busy,
   output logic [C_S_AXI_LITE_ADDR_WIDTH-1:0]     s_axi_lite_awaddr,
   output logic                                   s_axi_lite_awvalid,
   input  logic                                   s_axi_lite_awready,
   output logic [C_S_AXI_LITE_DATA_WIDTH-1:0]     s_axi_lite_wdata,
   output logic [C_S_AXI_LITE_DATA_WIDTH/8-1:0]   s_axi_lite_wstrb,
   output logic                                   s_axi_lite_wvalid,
   input  logic                                   s_axi_lite_wready,
   input  logic [1:0]                             s_axi_lite_bresp,
   input  logic                                   s_axi_lite_bvalid,
   output logic                                   s_axi_lite_bready,
   output logic [C_S_AXI_LITE_ADDR_WIDTH-1:0]     s_axi_lite_araddr,
   output logic                                   s_axi_lite_arvalid,
   input  logic                                   s_axi_lite_arready,
   input  logic [C_S_AXI_LITE_DATA_WIDTH-1:0]     s_axi_lite_rdata,
   input  logic [1:0]                             s_axi_lite_rresp,
   input  logic                                   s_axi_lite_rvalid,
   output logic                                   s_axi_lite_rready,
   output logic                                   err_timeout
);

   localparam int AW    = C_S_AXI_LITE_ADDR_WIDTH;
   localparam int DW    = C_S_AXI_LITE_DATA_WIDTH;
   localparam int IDX_W = $clog2(NUM_REQ);

   if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
      $error("rnic_lite_req_arbiter: unsupported parameter value");
   end

   typedef enum logic [2:0] {IDLE, WR_AW_W, WR_B, RD_AR, RD_R, DONE} state_t;

   state_t           state;
   logic [IDX_W-1:0] rr_ptr;
   logic [IDX_W-1:0] gnt_idx;
   logic [IDX_W-1:0] pick_idx;
   logic             pick_found;
   logic             aw_done;
   logic             w_done;
   logic             aw_done_n;
   logic             w_done_n;

   assign s_axi_lite_wstrb = '1;
   assign aw_done_n = aw_done | (s_axi_lite_awvalid & s_axi_lite_awready);
   assign w_done_n  = w_done  | (s_axi_lite_wvalid  & s_axi_lite_wready);

   // First pending requester at or above the round-robin pointer, wrapping.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!pick_found && req_valid[IDX_W'((int'(rr_ptr) + k) % NUM_REQ)]) begin
            pick_found = 1'b1;
            pick_idx   = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
         end
      end
   end

`ifdef RNIC_LITE_ARB_TIMEOUT_EN
   logic [15:0] tmo_cnt;
   state_t      prev_state;
   logic        tmo_hit;

   // tmo_cnt is stale in the first cycle of a state, hence the prev_state qualifier.
   assign tmo_hit = (state != IDLE) && (state != DONE) && (state == prev_state) &&
                    (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
   assign err_timeout = 1'b0;
`endif

   always_ff @(posedge s_axi_lite_aclk or negedge s_axi_lite_arstn) begin
      if (!s_axi_lite_arstn) begin
         state              <= IDLE;
         rr_ptr             <= '0;
         gnt_idx            <= '0;
         aw_done            <= 1'b0;
         w_done             <= 1'b0;
         req_ack            <= '0;
         req_done           <= '0;
         rsp_data           <= '0;
         rsp_resp           <= 2'b00;
         busy               <= 1'b0;
         s_axi_lite_awaddr  <= '0;
         s_axi_lite_awvalid <= 1'b0;
         s_axi_lite_wdata   <= '0;
         s_axi_lite_wvalid  <= 1'b0;
         s_axi_lite_bready  <= 1'b0;
         s_axi_lite_araddr  <= '0;
         s_axi_lite_arvalid <= 1'b0;
         s_axi_lite_rready  <= 1'b0;
`ifdef RNIC_LITE_ARB_TIMEOUT_EN
         tmo_cnt            <= '0;
         prev_state         <= IDLE;
         err_timeout        <= 1'b0;
`endif
      end else begin
         req_ack  <= '0;
         req_done <= '0;
         case (state)
            IDLE: begin
               if (pick_found) begin
                  req_ack[pick_idx] <= 1'b1;
                  busy              <= 1'b1;
                  gnt_idx           <= pick_idx;
                  rr_ptr            <= (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
                  s_axi_lite_awaddr <= req_addr[pick_idx*AW +: AW];
                  s_axi_lite_araddr <= req_addr[pick_idx*AW +: AW];
                  s_axi_lite_wdata  <= req_data[pick_idx*DW +: DW];
                  aw_done           <= 1'b0;
                  w_done            <= 1'b0;
                  state             <= req_wr[pick_idx] ? WR_AW_W : RD_AR;
               end
            end
            WR_AW_W: begin
               // Valids come up in the first cycle here, then drop on their own handshakes.
               s_axi_lite_awvalid <= !aw_done_n;
               s_axi_lite_wvalid  <= !w_done_n;
               aw_done            <= aw_done_n;
               w_done             <= w_done_n;
               if (aw_done_n && w_done_n) begin
                  s_axi_lite_bready <= 1'b1;
                  state             <= WR_B;
               end
            end
            WR_B: begin
               if (s_axi_lite_bvalid) begin
                  rsp_resp          <= s_axi_lite_bresp;
                  rsp_data          <= '0;
                  s_axi_lite_bready <= 1'b0;
                  req_done[gnt_idx] <= 1'b1;
                  busy              <= 1'b0;
                  state             <= DONE;
               end
            end
            RD_AR: begin
               if (s_axi_lite_arvalid && s_axi_lite_arready) begin
                  s_axi_lite_arvalid <= 1'b0;
                  s_axi_lite_rready  <= 1'b1;
                  state              <= RD_R;
               end else begin
                  s_axi_lite_arvalid <= 1'b1;
               end
            end
            RD_R: begin
               if (s_axi_lite_rvalid) begin
                  rsp_data          <= s_axi_lite_rdata;
                  rsp_resp          <= s_axi_lite_rresp;
                  s_axi_lite_rready <= 1'b0;
                  req_done[gnt_idx] <= 1'b1;
                  busy              <= 1'b0;
                  state             <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
`ifdef RNIC_LITE_ARB_TIMEOUT_EN
         prev_state <= state;
         tmo_cnt    <= (state != prev_state) ? 16'd1 : tmo_cnt + 16'd1;
         if (tmo_hit) begin
            s_axi_lite_awvalid <= 1'b0;
            s_axi_lite_wvalid  <= 1'b0;
            s_axi_lite_bready  <= 1'b0;
            s_axi_lite_arvalid <= 1'b0;
            s_axi_lite_rready  <= 1'b0;
            req_done           <= '0;
            req_done[gnt_idx]  <= 1'b1;
            rsp_resp           <= 2'b10;
            rsp_data           <= '0;
            busy               <= 1'b0;
            err_timeout        <= 1'b1;
            state              <= IDLE;
         end
`endif
      end
   end

endmodule

// File: tb/tb_rnic_lite_req_arbiter.sv
// tb/tb_rnic_lite_req_arbiter.sv - randomized scoreboard bench for rnic_lite_req_arbiter

module tb_rnic_lite_req_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int N  = 3;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [N-1:0]    req_valid = '0;
   logic [N-1:0]    req_wr = '0;
   logic [N*AW-1:0] req_addr = '0;
   logic [N*DW-1:0] req_data = '0;
   logic [N-1:0]    req_ack;
   logic [N-1:0]    req_done;
   logic [DW-1:0]   rsp_data;
   logic [1:0]      rsp_resp;
   logic            busy;
   logic [AW-1:0]   awaddr;
   logic            awvalid;
   logic            awready = 1'b0;
   logic [DW-1:0]   wdata;
   logic [DW/8-1:0] wstrb;
   logic            wvalid;
   logic            wready = 1'b0;
   logic [1:0]      bresp = 2'b00;
   logic            bvalid = 1'b0;
   logic            bready;
   logic [AW-1:0]   araddr;
   logic            arvalid;
   logic            arready = 1'b0;
   logic [DW-1:0]   rdata = '0;
   logic [1:0]      rresp = 2'b00;
   logic            rvalid = 1'b0;
   logic            rready;
   logic            err_timeout;

   always #5 clk = ~clk;

   rnic_lite_req_arbiter #(
      .C_S_AXI_LITE_ADDR_WIDTH(AW), .C_S_AXI_LITE_DATA_WIDTH(DW),
      .NUM_REQ(N), .TIMEOUT_CYCLES(1024)
   ) dut (
      .s_axi_lite_aclk(clk), .s_axi_lite_arstn(rst_n),
      .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr), .req_data(req_data),
      .req_ack(req_ack), .req_done(req_done), .rsp_data(rsp_data), .rsp_resp(rsp_resp),
      .busy(busy),
      .s_axi_lite_awaddr(awaddr), .s_axi_lite_awvalid(awvalid), .s_axi_lite_awready(awready),
      .s_axi_lite_wdata(wdata), .s_axi_lite_wstrb(wstrb), .s_axi_lite_wvalid(wvalid),
      .s_axi_lite_wready(wready),
      .s_axi_lite_bresp(bresp), .s_axi_lite_bvalid(bvalid), .s_axi_lite_bready(bready),
      .s_axi_lite_araddr(araddr), .s_axi_lite_arvalid(arvalid), .s_axi_lite_arready(arready),
      .s_axi_lite_rdata(rdata), .s_axi_lite_rresp(rresp), .s_axi_lite_rvalid(rvalid),
      .s_axi_lite_rready(rready),
      .err_timeout(err_timeout)
   );

   typedef struct {
      int            idx;
      logic          wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } txn_t;

   typedef struct {
      int            idx;
      logic [1:0]    resp;
      logic [DW-1:0] data;
   } rsp_t;

   txn_t exp_axi[$];
   rsp_t exp_done[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   inflight = 0;
   int   model_ptr = 0;
   int   prob[N];
   int   rdy_pct = 70;
   bit   rd_only = 1'b0;
   bit   stall_r = 1'b0;
   bit   s_ar_got = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Values the DUT saw at each rising edge.
   logic [N-1:0]    rv_s, rw_s;
   logic [N*AW-1:0] ra_s;
   logic [N*DW-1:0] rd_s;
   logic            aw_hs, w_hs, b_hs, ar_hs, r_hs;
   logic [AW-1:0]   awaddr_s, araddr_s;
   logic [DW-1:0]   wdata_s;
   logic [DW/8-1:0] wstrb_s;

   always @(posedge clk) begin
      rv_s     <= req_valid;
      rw_s     <= req_wr;
      ra_s     <= req_addr;
      rd_s     <= req_data;
      aw_hs    <= awvalid && awready;
      w_hs     <= wvalid && wready;
      b_hs     <= bvalid && bready;
      ar_hs    <= arvalid && arready;
      r_hs     <= rvalid && rready;
      awaddr_s <= awaddr;
      araddr_s <= araddr;
      wdata_s  <= wdata;
      wstrb_s  <= wstrb;
   end

   // Requester model: raise at random, drop on ack, stay quiet until done.
   initial begin
      bit [N-1:0] outst;
      outst = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            outst = '0;
         end else begin
            for (int i = 0; i < N; i++) begin
               if (req_done[i]) outst[i] = 1'b0;
               if (req_valid[i] && req_ack[i]) begin
                  req_valid[i] = 1'b0;
                  outst[i]     = 1'b1;
               end else if (!req_valid[i] && !outst[i] && $urandom_range(0, 99) < prob[i]) begin
                  req_wr[i]              = rd_only ? 1'b0 : 1'($urandom);
                  req_addr[i*AW +: AW]   = $urandom & 32'hFFFF_FFFC;
                  req_data[i*DW +: DW]   = $urandom;
                  req_valid[i]           = 1'b1;
               end
            end
         end
      end
   end

   // Grant monitor: round-robin reference over the pending set the DUT sampled.
   initial begin
      int         pick;
      logic [N-1:0] e;
      txn_t       t;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            model_ptr = 0;
         end else if (req_ack != '0) begin
            pick = -1;
            for (int k = 0; k < N; k++)
               if (pick < 0 && rv_s[(model_ptr + k) % N]) pick = (model_ptr + k) % N;
            if (pick < 0) begin
               check("ack_without_request", 64'(req_ack), 64'd0);
            end else begin
               e = '0;
               e[pick] = 1'b1;
               check("ack_grant", 64'(req_ack), 64'(e));
               check("ack_while_inflight", 64'(inflight), 64'd0);
               check("ack_busy", 64'(busy), 64'd1);
               t.idx  = pick;
               t.wr   = rw_s[pick];
               t.addr = ra_s[pick*AW +: AW];
               t.data = rd_s[pick*DW +: DW];
               exp_axi.push_back(t);
               inflight++;
               model_ptr = (pick + 1) % N;
            end
         end
      end
   end

   // Completion monitor.
   initial begin
      rsp_t         r;
      logic [N-1:0] e;
      forever begin
         @(negedge clk);
         if (rst_n && req_done != '0) begin
            if (exp_done.size() == 0) begin
               check("done_unexpected", 64'(req_done), 64'd0);
            end else begin
               r = exp_done.pop_front();
               e = '0;
               e[r.idx] = 1'b1;
               check("done_vector", 64'(req_done), 64'(e));
               check("done_resp", 64'(rsp_resp), 64'(r.resp));
               check("done_data", 64'(rsp_data), 64'(r.data));
               check("done_busy", 64'(busy), 64'd0);
               inflight--;
            end
         end
      end
   end

   // AXI-Lite slave with random ready timing and response delays.
   initial begin
      bit s_aw_got, s_w_got, b_pend;
      int bdly, rdly;
      rsp_t r;
      s_aw_got = 1'b0; s_w_got = 1'b0; b_pend = 1'b0; bdly = 0; rdly = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            s_aw_got = 1'b0; s_w_got = 1'b0; b_pend = 1'b0; s_ar_got = 1'b0;
            awready = 1'b0; wready = 1'b0; arready = 1'b0; bvalid = 1'b0; rvalid = 1'b0;
         end else begin
            if (aw_hs) begin
               if (exp_axi.size() == 0) check("aw_unexpected", 64'd1, 64'd0);
               else begin
                  check("aw_is_write", 64'(exp_axi[0].wr), 64'd1);
                  check("awaddr", 64'(awaddr_s), 64'(exp_axi[0].addr));
               end
               s_aw_got = 1'b1;
            end
            if (w_hs) begin
               if (exp_axi.size() == 0) check("w_unexpected", 64'd1, 64'd0);
               else begin
                  check("wdata", 64'(wdata_s), 64'(exp_axi[0].data));
                  check("wstrb", 64'(wstrb_s), 64'hF);
               end
               s_w_got = 1'b1;
            end
            if (b_hs) begin
               bvalid = 1'b0; s_aw_got = 1'b0; s_w_got = 1'b0;
               if (exp_axi.size() > 0) void'(exp_axi.pop_front());
            end
            if (s_aw_got && s_w_got && !bvalid && !b_pend) begin
               b_pend = 1'b1;
               bdly   = $urandom_range(0, 3);
            end
            if (b_pend) begin
               if (bdly == 0) begin
                  b_pend = 1'b0;
                  bresp  = 2'($urandom);
                  bvalid = 1'b1;
                  r.idx  = (exp_axi.size() > 0) ? exp_axi[0].idx : -1;
                  r.resp = bresp;
                  r.data = '0;
                  exp_done.push_back(r);
               end else bdly--;
            end
            if (ar_hs) begin
               if (exp_axi.size() == 0) check("ar_unexpected", 64'd1, 64'd0);
               else begin
                  check("ar_is_read", 64'(exp_axi[0].wr), 64'd0);
                  check("araddr", 64'(araddr_s), 64'(exp_axi[0].addr));
               end
               s_ar_got = 1'b1;
               rdly     = $urandom_range(0, 4);
            end
            if (r_hs) begin
               rvalid = 1'b0; s_ar_got = 1'b0;
               if (exp_axi.size() > 0) void'(exp_axi.pop_front());
            end
            if (s_ar_got && !rvalid && !stall_r) begin
               if (rdly == 0) begin
                  rdata  = $urandom;
                  rresp  = 2'($urandom);
                  rvalid = 1'b1;
                  r.idx  = (exp_axi.size() > 0) ? exp_axi[0].idx : -1;
                  r.resp = rresp;
                  r.data = rdata;
                  exp_done.push_back(r);
               end else rdly--;
            end
            awready = !s_aw_got && ($urandom_range(0, 99) < rdy_pct);
            wready  = !s_w_got  && ($urandom_range(0, 99) < rdy_pct);
            arready = !s_ar_got && ($urandom_range(0, 99) < rdy_pct);
         end
      end
   end

   task automatic set_prob(input int p0, input int p1, input int p2);
      prob[0] = p0; prob[1] = p1; prob[2] = p2;
   endtask

   task automatic drain();
      int t;
      set_prob(0, 0, 0);
      t = 0;
      while ((req_valid != '0 || inflight != 0 || busy) && t < 500) begin
         @(negedge clk);
         t++;
      end
      check("drain_within_bound", 64'(t < 500), 64'd1);
   endtask

   initial begin
      #600000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   initial begin
      int t;
      set_prob(0, 0, 0);
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_req_ack", 64'(req_ack), 64'd0);
      check("rst_req_done", 64'(req_done), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_awvalid", 64'(awvalid), 64'd0);
      check("rst_wvalid", 64'(wvalid), 64'd0);
      check("rst_arvalid", 64'(arvalid), 64'd0);
      check("rst_bready", 64'(bready), 64'd0);
      check("rst_rready", 64'(rready), 64'd0);
      check("rst_rsp_data", 64'(rsp_data), 64'd0);
      check("rst_rsp_resp", 64'(rsp_resp), 64'd0);
      check("rst_awaddr", 64'(awaddr), 64'd0);
      check("rst_araddr", 64'(araddr), 64'd0);
      check("rst_err_timeout", 64'(err_timeout), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      rdy_pct = 70;  set_prob(30, 30, 30);    repeat (600) @(negedge clk);
      rdy_pct = 100; set_prob(100, 100, 100); repeat (300) @(negedge clk);
      rdy_pct = 35;                           repeat (300) @(negedge clk);
      rdy_pct = 80;  set_prob(0, 100, 0);     repeat (200) @(negedge clk);
      drain();

      // Reset while a read waits for its data; a later request must win first afterwards.
      stall_r = 1'b1;
      rd_only = 1'b1;
      set_prob(0, 0, 100);
      t = 0;
      while (!req_ack[2] && t < 50) begin @(negedge clk); t++; end
      check("stall_read_ack2", 64'(req_ack[2]), 64'd1);
      set_prob(0, 0, 0);
      t = 0;
      while (!rready && t < 50) begin @(negedge clk); t++; end
      check("stall_read_in_rd_r", 64'(rready), 64'd1);
      set_prob(0, 100, 0);
      repeat (2) @(negedge clk);
      set_prob(0, 0, 0);
      check("req1_held_pending", 64'(req_valid[1]), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_busy", 64'(busy), 64'd0);
      check("midrst_rready", 64'(rready), 64'd0);
      check("midrst_arvalid", 64'(arvalid), 64'd0);
      check("midrst_araddr", 64'(araddr), 64'd0);
      check("midrst_rsp_data", 64'(rsp_data), 64'd0);
      check("midrst_req_done", 64'(req_done), 64'd0);
      exp_axi.delete();
      exp_done.delete();
      inflight = 0;
      stall_r  = 1'b0;
      repeat (2) @(negedge clk);
      @(posedge clk);
      #2 rst_n = 1'b1;
      t = 0;
      while (req_ack == '0 && t < 50) begin @(negedge clk); t++; end
      check("first_grant_after_reset", 64'(req_ack), 64'b010);
      rd_only = 1'b0;
      drain();

      check("final_axi_queue_empty", 64'(exp_axi.size()), 64'd0);
      check("final_done_queue_empty", 64'(exp_done.size()), 64'd0);
      check("final_err_timeout", 64'(err_timeout), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
